// File: rtl/grf_sb_multiport.sv
// rtl/grf_sb_multiport.sv - multi-port register file with write bypass and busy scoreboard (optional trace: GRF_TRACE_EN)
module grf_sb_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [31:0]              pc,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     issue_vld,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic [ADDR_W:0]   cnt_next;

    // Register array update; port 1 is written last so it wins on a shared index
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0 && waddr0 != '0) begin
                regs[waddr0] <= wdata0;
            end
            if (we1 && waddr1 != '0) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    // Next scoreboard state: a new issue overrides a completing write to the same register
    always_comb begin
        busy_next = busy;
        cnt_next  = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (issue_vld && issue_addr == ADDR_W'(i)) begin
                busy_next[i] = 1'b1;
            end else if ((we0 && waddr0 == ADDR_W'(i)) || (we1 && waddr1 == ADDR_W'(i))) begin
                busy_next[i] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    // Scoreboard and its population count are registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    // Read ports: $0 is hard zero, then same-cycle write bypass (port 1 first), then the array
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] ra;
            logic              wr_hit;
            ra     = raddr[k*ADDR_W +: ADDR_W];
            wr_hit = (we0 && waddr0 == ra) || (we1 && waddr1 == ra);
            if (ra == '0) begin
                rdata[k*DATA_W +: DATA_W] = '0;
            end else if (we1 && waddr1 == ra) begin
                rdata[k*DATA_W +: DATA_W] = wdata1;
            end else if (we0 && waddr0 == ra) begin
                rdata[k*DATA_W +: DATA_W] = wdata0;
            end else begin
                rdata[k*DATA_W +: DATA_W] = regs[ra];
            end
            rbusy[k] = (ra != '0) && busy[ra] && !wr_hit;
        end
    end

`ifdef GRF_TRACE_EN
    // Write trace, port 0 line before port 1, writes to $0 included
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (we0) begin
                $display("%d@%h: $%d <= %h", $time, pc, waddr0, wdata0);
            end
            if (we1) begin
                $display("%d@%h: $%d <= %h", $time, pc, waddr1, wdata1);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_grf_sb_multiport.sv
// tb/tb_grf_sb_multiport.sv - table-driven bench for grf_sb_multiport
module tb_grf_sb_multiport;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     we0, we1, issue_vld;
    logic [ADDR_W-1:0]        waddr0, waddr1, issue_addr;
    logic [DATA_W-1:0]        wdata0, wdata1;
    logic [31:0]              pc;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic [ADDR_W:0]          busy_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    grf_sb_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .pc(pc), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .issue_vld(issue_vld), .issue_addr(issue_addr), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rbusy;
        logic [5:0]  e_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rst,
                                input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                input logic iv, input logic [4:0] ia,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] x0, input logic [31:0] x1,
                                input logic [1:0] xb, input logic [5:0] xc);
        vec_t v;
        v = '{rst, w0, a0, d0, w1, a1, d1, iv, ia, r0, r1, x0, x1, xb, xc};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_idle();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; issue_vld = 1'b0;
        waddr0 = '0; waddr1 = '0; issue_addr = '0;
        wdata0 = '0; wdata1 = '0;
    endtask

    initial begin
        //        rst we0 wa0 wd0           we1 wa1 wd1     iv ia  ra0 ra1 rd0           rd1        rbusy cnt
        vecs[0]  = mk(0, 1, 5, 32'h1234,     0, 0, 0,         0, 0,  5, 0,  32'h1234,     0,         2'b00, 0);
        vecs[1]  = mk(0, 0, 0, 0,            0, 0, 0,         0, 0,  5, 5,  32'h1234,     32'h1234,  2'b00, 0);
        vecs[2]  = mk(0, 1, 7, 32'hAAAA,     1, 7, 32'h5555,  0, 0,  7, 5,  32'h5555,     32'h1234,  2'b00, 0);
        vecs[3]  = mk(0, 0, 0, 0,            0, 0, 0,         0, 0,  7, 7,  32'h5555,     32'h5555,  2'b00, 0);
        vecs[4]  = mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,         1, 0,  0, 7,  0,            32'h5555,  2'b00, 0);
        vecs[5]  = mk(0, 0, 0, 0,            0, 0, 0,         0, 0,  0, 0,  0,            0,         2'b00, 0);
        vecs[6]  = mk(0, 0, 0, 0,            0, 0, 0,         1, 3,  3, 4,  0,            0,         2'b00, 0);
        vecs[7]  = mk(0, 0, 0, 0,            0, 0, 0,         1, 4,  3, 4,  0,            0,         2'b01, 1);
        vecs[8]  = mk(0, 1, 3, 32'h33,       0, 0, 0,         1, 3,  3, 4,  32'h33,       0,         2'b10, 2);
        vecs[9]  = mk(0, 0, 0, 0,            1, 4, 32'h44,    0, 0,  3, 4,  32'h33,       32'h44,    2'b01, 2);
        vecs[10] = mk(0, 0, 0, 0,            0, 0, 0,         0, 0,  3, 4,  32'h33,       32'h44,    2'b01, 1);
        vecs[11] = mk(0, 1, 3, 32'h30,       0, 0, 0,         0, 0,  3, 4,  32'h30,       32'h44,    2'b00, 1);
        vecs[12] = mk(0, 0, 0, 0,            0, 0, 0,         1, 9,  9, 3,  0,            32'h30,    2'b00, 0);
        vecs[13] = mk(0, 0, 0, 0,            0, 0, 0,         1, 9,  9, 3,  0,            32'h30,    2'b01, 1);
        vecs[14] = mk(1, 1, 9, 32'h99,       0, 0, 0,         1, 10, 9, 7,  32'h99,       32'h5555,  2'b00, 1);
        vecs[15] = mk(0, 0, 0, 0,            0, 0, 0,         0, 0,  9, 7,  0,            0,         2'b00, 0);
        vecs[16] = mk(0, 0, 0, 0,            0, 0, 0,         0, 0,  10, 3, 0,            0,         2'b00, 0);
        vecs[17] = mk(0, 1, 31, 32'hDEAD,    1, 1, 32'hBEEF,  0, 0,  31, 1, 32'hDEAD,     32'hBEEF,  2'b00, 0);
        vecs[18] = mk(0, 0, 0, 0,            0, 0, 0,         0, 0,  31, 1, 32'hDEAD,     32'hBEEF,  2'b00, 0);

        pc = 32'h0000_1000;
        raddr = '0;
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // After reset every register reads zero and nothing is busy
        for (int r = 0; r < 32; r++) begin
            raddr = {5'(31 - r), 5'(r)};
            #1;
            chk($sformatf("reset_rd0_r%0d", r), rdata[31:0], 32'h0);
            chk($sformatf("reset_rd1_r%0d", 31 - r), rdata[63:32], 32'h0);
            chk($sformatf("reset_rbusy_r%0d", r), {30'b0, rbusy}, 32'h0);
        end
        chk("reset_busy_cnt", {26'b0, busy_cnt}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset      = vecs[i].rst;
            we0        = vecs[i].we0;
            waddr0     = vecs[i].wa0;
            wdata0     = vecs[i].wd0;
            we1        = vecs[i].we1;
            waddr1     = vecs[i].wa1;
            wdata1     = vecs[i].wd1;
            issue_vld  = vecs[i].iv;
            issue_addr = vecs[i].ia;
            raddr      = {vecs[i].ra1, vecs[i].ra0};
            pc         = pc + 32'd4;
            #1;
            chk($sformatf("v%0d_rdata0", i), rdata[31:0], vecs[i].e_rd0);
            chk($sformatf("v%0d_rdata1", i), rdata[63:32], vecs[i].e_rd1);
            chk($sformatf("v%0d_rbusy", i), {30'b0, rbusy}, {30'b0, vecs[i].e_rbusy});
            chk($sformatf("v%0d_busy_cnt", i), {26'b0, busy_cnt}, {26'b0, vecs[i].e_cnt});
        end

        // Fill the scoreboard completely: count saturates at NREGS-1 and never wraps
        @(negedge clk);
        drive_idle();
        for (int r = 1; r < 32; r++) begin
            issue_vld  = 1'b1;
            issue_addr = 5'(r);
            @(negedge clk);
        end
        issue_vld  = 1'b1;
        issue_addr = 5'd0;
        @(negedge clk);
        drive_idle();
        raddr = {5'd31, 5'd0};
        #1;
        chk("full_busy_cnt", {26'b0, busy_cnt}, 32'd31);
        chk("full_rbusy", {30'b0, rbusy}, 32'b10);
        @(negedge clk);
        #1;
        chk("full_busy_cnt_hold", {26'b0, busy_cnt}, 32'd31);

        // Two writes clearing two different registers in the same cycle
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd13; wdata1 = 32'h2;
        @(negedge clk);
        drive_idle();
        #1;
        chk("dual_clear_busy_cnt", {26'b0, busy_cnt}, 32'd29);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
